// File: rtl/instruction_memory_loadable.sv
// Run-time loadable instruction store: clear, length-prefixed load over
// valid/ready, then registered single-cycle fetches while idle.
module instruction_memory_loadable #(
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    DEPTH      = 32,
  parameter logic [DATA_WIDTH-1:0] FILL_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_start,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  ld_ready,
  output logic                  load_busy,
  output logic                  load_done,
  output logic                  load_err,
  input  logic                  fetch_en,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic [DATA_WIDTH-1:0] fetch_data,
  output logic                  fetch_valid
);

  // Counter wide enough to count past both DEPTH and any length word.
  localparam int CW = ((ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_C  = CW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, LOAD_LEN, LOAD_DATA} state_t;

  state_t                  state, state_next;
  logic [CW-1:0]           cnt, cnt_next;
  logic [DATA_WIDTH-1:0]   n_len, n_next;
  logic                    err_next, done_next;
  logic                    xfer;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    fetch_go;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // Next-state, counter and write-port decode; load_start overrides every state.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    n_next     = n_len;
    err_next   = load_err;
    done_next  = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = FILL_VALUE;
    mem_waddr  = cnt[ADDR_WIDTH-1:0];
    ld_ready   = (state == LOAD_LEN) || (state == LOAD_DATA);
    load_busy  = (state != IDLE);
    xfer       = ld_valid && ld_ready;
    fetch_go   = (state == IDLE) && fetch_en && !load_start;
    if (load_start) begin
      state_next = CLEAR;
      cnt_next   = '0;
      err_next   = 1'b0;
    end else begin
      unique case (state)
        IDLE: ;
        CLEAR: begin
          mem_we = 1'b1;
          if (cnt == LAST_C) begin
            state_next = LOAD_LEN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
        LOAD_LEN: begin
          if (xfer) begin
            n_next   = ld_data;
            cnt_next = '0;
            if (CW'(ld_data) > DEPTH_C) err_next = 1'b1;
            if (ld_data == '0) begin
              state_next = IDLE;
              done_next  = 1'b1;
            end else begin
              state_next = LOAD_DATA;
            end
          end
        end
        LOAD_DATA: begin
          if (xfer) begin
            // Words beyond DEPTH are accepted but dropped.
            if (cnt < DEPTH_C) begin
              mem_we    = 1'b1;
              mem_wdata = ld_data;
            end
            if (cnt + CW'(1) == CW'(n_len)) begin
              state_next = IDLE;
              done_next  = 1'b1;
            end else begin
              cnt_next = cnt + CW'(1);
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Control registers and registered fetch port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      n_len       <= '0;
      load_err    <= 1'b0;
      load_done   <= 1'b0;
      fetch_valid <= 1'b0;
      fetch_data  <= FILL_VALUE;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      n_len       <= n_next;
      load_err    <= err_next;
      load_done   <= done_next;
      fetch_valid <= fetch_go;
      if (fetch_go)
        fetch_data <= (CW'(fetch_addr) < DEPTH_C) ? mem[fetch_addr] : FILL_VALUE;
    end
  end

  // Storage array; deliberately not reset so a reset keeps partial contents.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

endmodule

// File: tb/tb_instruction_memory_loadable.sv
// Directed + randomized bench for instruction_memory_loadable with an
// array-based reference model of the program store.
module tb_instruction_memory_loadable;

  localparam int DEPTH = 32;
  localparam logic [7:0] FILL = 8'h00;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_start = 1'b0;
  logic       ld_valid = 1'b0;
  logic [7:0] ld_data = '0;
  logic       ld_ready, load_busy, load_done, load_err;
  logic       fetch_en = 1'b0;
  logic [4:0] fetch_addr = '0;
  logic [7:0] fetch_data;
  logic       fetch_valid;

  int errors = 0;
  int checks = 0;

  logic [7:0] model_mem [DEPTH];
  bit         model_err;
  logic [7:0] prog [$];

  instruction_memory_loadable #(
    .ADDR_WIDTH(5), .DATA_WIDTH(8), .DEPTH(DEPTH), .FILL_VALUE(FILL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .load_busy(load_busy), .load_done(load_done), .load_err(load_err),
    .fetch_en(fetch_en), .fetch_addr(fetch_addr),
    .fetch_data(fetch_data), .fetch_valid(fetch_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse load_start and wait out the clear phase; model store becomes all FILL.
  task automatic start_load(input bit hf);
    int n;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("busy_after_start", load_busy, 1);
    chk("err_cleared", load_err, 0);
    chk("ready_in_clear", ld_ready, 0);
    if (hf) chk("fv_on_start", fetch_valid, 0);
    n = 0;
    while (!ld_ready && n < 200) begin
      tick();
      n++;
      if (hf) chk("fv_in_clear", fetch_valid, 0);
    end
    chk("clear_cycles", n, DEPTH);
    for (int a = 0; a < DEPTH; a++) model_mem[a] = FILL;
  endtask

  task automatic send(input logic [7:0] w, input bit hf);
    int st;
    st = $urandom_range(0, 2);
    ld_valid = 1'b0;
    for (int i = 0; i < st; i++) begin
      tick();
      chk("ready_during_stall", ld_ready, 1);
      if (hf) chk("fv_stall", fetch_valid, 0);
    end
    ld_valid = 1'b1;
    ld_data  = w;
    tick();
    ld_valid = 1'b0;
    if (hf) chk("fv_xfer", fetch_valid, 0);
  endtask

  // Full load of the words in prog, length word = prog.size().
  task automatic run_load(input bit hf);
    int n;
    n = prog.size();
    fetch_en = hf;
    start_load(hf);
    model_err = (n > DEPTH);
    send(8'(n), hf);
    chk("err_after_len", load_err, model_err);
    for (int k = 0; k < n; k++) begin
      chk("done_early", load_done, 0);
      send(prog[k], hf);
      if (k < DEPTH) model_mem[k] = prog[k];
    end
    chk("done_pulse", load_done, 1);
    chk("busy_after_done", load_busy, 0);
    chk("ready_after_done", ld_ready, 0);
    chk("err_final", load_err, model_err);
    tick();
    chk("done_one_cycle", load_done, 0);
    if (hf) chk("fv_after_load", fetch_valid, 1);
    fetch_en = 1'b0;
  endtask

  task automatic check_all();
    logic [7:0] last;
    for (int a = 0; a < DEPTH; a++) begin
      fetch_en   = 1'b1;
      fetch_addr = 5'(a);
      tick();
      chk("fetch_valid", fetch_valid, 1);
      chk($sformatf("fetch_data[%0d]", a), fetch_data, model_mem[a]);
    end
    last = model_mem[DEPTH-1];
    fetch_en = 1'b0;
    fetch_addr = 5'd3;
    tick();
    chk("fetch_idle_valid", fetch_valid, 0);
    chk("fetch_hold", fetch_data, last);
  endtask

  initial begin
    // Reset values
    #12;
    chk("rst_ready", ld_ready, 0);
    chk("rst_busy", load_busy, 0);
    chk("rst_done", load_done, 0);
    chk("rst_err", load_err, 0);
    chk("rst_fv", fetch_valid, 0);
    chk("rst_fd", fetch_data, FILL);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    fetch_en = 1'b1;
    tick();
    chk("first_fetch_valid", fetch_valid, 1);
    fetch_en = 1'b0;

    // Directed program 35,00,30
    prog = {8'h35, 8'h00, 8'h30};
    run_load(0);
    check_all();

    // Empty program
    prog = {};
    run_load(0);
    check_all();

    // Oversized program: 34 words 0..33, extras dropped
    prog = {};
    for (int i = 0; i < 34; i++) prog.push_back(8'(i));
    run_load(0);
    check_all();

    // Abort mid-data, reload one word
    start_load(0);
    send(8'd5, 0);
    send(8'h11, 0);
    send(8'h22, 0);
    prog = {8'hA9};
    run_load(0);
    check_all();

    // Fetch held during a load
    prog = {8'h01, 8'h02, 8'h03, 8'h04};
    run_load(1);
    check_all();

    // Async reset mid-data: partial contents kept, err cleared
    start_load(0);
    send(8'd40, 0);
    chk("err_before_rst", load_err, 1);
    send(8'h5A, 0);
    send(8'hC3, 0);
    model_mem[0] = 8'h5A;
    model_mem[1] = 8'hC3;
    rst_n = 1'b0;
    #1;
    chk("async_busy", load_busy, 0);
    chk("async_ready", ld_ready, 0);
    chk("async_err", load_err, 0);
    #1;
    rst_n = 1'b1;
    tick();
    check_all();

    // Randomized programs
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(0, 40);
      prog = {};
      for (int i = 0; i < n; i++) prog.push_back(8'($urandom));
      run_load(bit'($urandom_range(0, 1)));
      check_all();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
